sr_latch_monitor: RTL and testbench

Synthesizable, clocked checker for the NOR-type SR latch (`sr_latch`, ports S, R, Q, Qbar) that sits on the observing side of the latch. The stimulus driver writes S/R; this block samples S, R, Q and Qbar every clock and tracks the expected latch state with a small state machine. It flags functional mismatches, counts them, and records any use of the forbidden S=R=1 input. It is instantiated beside the latch in simulation and FPGA bring-up builds.

---
 rtl/sr_latch_monitor_if.sv | 12 +
 rtl/sr_latch_monitor.sv | 187 ++++++++++++++++++
 tb/tb_sr_latch_monitor.sv | 335 +++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/sr_latch_monitor_if.sv
// Observation bus between an SR latch and its monitor.
// The driver side (stimulus plus the latch under test) owns s/r/q/qbar;
// the monitor only samples them.
interface sr_latch_monitor_if;
  logic s;
  logic r;
  logic q;
  logic qbar;

  modport master (output s, output r, output q, output qbar);
  modport slave  (input  s, input  r, input  q, input  qbar);
endinterface

// File: rtl/sr_latch_monitor.sv
// sr_latch_monitor: clocked checker for a NOR-type SR latch.
// It samples S/R/Q/Qbar every clock and tracks the expected latch state.
// It waits out a settle window after every S/R change, then flags value
// mismatches (01), complement violations (10) and bad forbidden-state
// outputs (11). Errors go into a saturating counter, and any sampled
// S=R=1 sets a sticky flag.
// Optional feature macro: SRMON_FORBID_CHECK_EN. When it is defined, the
// FORBID state requires q=qbar=0. When it is not defined, FORBID checks
// nothing.
module sr_latch_monitor #(
  parameter int unsigned SETTLE_CYCLES = 2,
  parameter int unsigned CNT_W         = 8
) (
  input  logic                 clk,
  input  logic                 rst,
  sr_latch_monitor_if.slave    lat,
  input  logic                 clear,
  output logic                 exp_q,
  output logic                 exp_valid,
  output logic                 err,
  output logic [1:0]           err_code,
  output logic [CNT_W-1:0]     err_count,
  output logic                 invalid_seen
);

  typedef enum logic [1:0] {
    ST_UNK    = 2'd0,
    ST_SETTLE = 2'd1,
    ST_CHECK  = 2'd2,
    ST_FORBID = 2'd3
  } state_t;

  localparam logic [3:0]       SETTLE_LOAD = 4'(SETTLE_CYCLES);
  localparam logic [CNT_W-1:0] CNT_MAX     = '1;
  localparam logic [1:0]       CODE_VALUE  = 2'b01;
  localparam logic [1:0]       CODE_COMPL  = 2'b10;
  localparam logic [1:0]       CODE_FORBID = 2'b11;

  state_t           state_q, state_d;
  state_t           target_q, target_d;
  logic [3:0]       cnt_q, cnt_d;
  logic [1:0]       prev_sr_q, prev_sr_d;
  logic             exp_q_q, exp_q_d;
  logic             exp_valid_q, exp_valid_d;
  logic             err_q, err_d;
  logic [1:0]       err_code_q, err_code_d;
  logic [CNT_W-1:0] err_count_q, err_count_d;
  logic             invalid_seen_q, invalid_seen_d;

  logic [1:0]       sr;
  logic             change;
  logic             hit;
  logic [1:0]       hit_code;
  state_t           new_target;

  // Next-state logic: expectation tracking, settle window, checks and error bookkeeping
  always_comb begin
    sr             = {lat.s, lat.r};
    change         = (sr != prev_sr_q);
    hit            = 1'b0;
    hit_code       = 2'b00;
    new_target     = ST_UNK;
    state_d        = state_q;
    target_d       = target_q;
    cnt_d          = cnt_q;
    prev_sr_d      = sr;
    exp_q_d        = exp_q_q;
    exp_valid_d    = exp_valid_q;
    err_d          = 1'b0;
    err_code_d     = err_code_q;
    err_count_d    = err_count_q;
    invalid_seen_d = invalid_seen_q | (sr == 2'b11);

    if (change) begin
      case (sr)
        2'b10: begin
          exp_q_d     = 1'b1;
          exp_valid_d = 1'b1;
          new_target  = ST_CHECK;
        end
        2'b01: begin
          exp_q_d     = 1'b0;
          exp_valid_d = 1'b1;
          new_target  = ST_CHECK;
        end
        2'b11: begin
          exp_valid_d = 1'b0;
          new_target  = ST_FORBID;
        end
        default: begin
          // Leaving S=R=1 for hold is a release race: the final state is unknown
          if (prev_sr_q == 2'b11) begin
            exp_valid_d = 1'b0;
            new_target  = ST_UNK;
          end else begin
            new_target  = exp_valid_q ? ST_CHECK : ST_UNK;
          end
        end
      endcase
      target_d = new_target;
      if (SETTLE_CYCLES == 0) begin
        state_d = new_target;
      end else begin
        state_d = ST_SETTLE;
        cnt_d   = SETTLE_LOAD;
      end
    end else begin
      case (state_q)
        ST_SETTLE: begin
          if (cnt_q <= 4'd1) begin
            state_d = target_q;
            cnt_d   = 4'd0;
          end else begin
            cnt_d   = cnt_q - 4'd1;
          end
        end
        ST_CHECK: begin
          if (lat.q == lat.qbar) begin
            hit      = 1'b1;
            hit_code = CODE_COMPL;
          end else if (lat.q != exp_q_q) begin
            hit      = 1'b1;
            hit_code = CODE_VALUE;
          end
        end
`ifdef SRMON_FORBID_CHECK_EN
        ST_FORBID: begin
          if (lat.q || lat.qbar) begin
            hit      = 1'b1;
            hit_code = CODE_FORBID;
          end
        end
`endif
        default: ;
      endcase
    end

    if (hit) begin
      err_d      = 1'b1;
      err_code_d = hit_code;
      if (err_count_q != CNT_MAX) begin
        err_count_d = err_count_q + CNT_W'(1);
      end
    end

    // Clear wins over a same-cycle increment, but a fresh S=R=1 sample still registers
    if (clear) begin
      err_count_d    = '0;
      invalid_seen_d = (sr == 2'b11);
    end
  end

  // State and output registers, cleared immediately on reset
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q        <= ST_UNK;
      target_q       <= ST_UNK;
      cnt_q          <= 4'd0;
      prev_sr_q      <= 2'b00;
      exp_q_q        <= 1'b0;
      exp_valid_q    <= 1'b0;
      err_q          <= 1'b0;
      err_code_q     <= 2'b00;
      err_count_q    <= '0;
      invalid_seen_q <= 1'b0;
    end else begin
      state_q        <= state_d;
      target_q       <= target_d;
      cnt_q          <= cnt_d;
      prev_sr_q      <= prev_sr_d;
      exp_q_q        <= exp_q_d;
      exp_valid_q    <= exp_valid_d;
      err_q          <= err_d;
      err_code_q     <= err_code_d;
      err_count_q    <= err_count_d;
      invalid_seen_q <= invalid_seen_d;
    end
  end

  assign exp_q        = exp_q_q;
  assign exp_valid    = exp_valid_q;
  assign err          = err_q;
  assign err_code     = err_code_q;
  assign err_count    = err_count_q;
  assign invalid_seen = invalid_seen_q;

endmodule

// File: tb/tb_sr_latch_monitor.sv
// Testbench for sr_latch_monitor: directed scenarios plus a randomized run
// checked against a behavioural model. The model counts edges since the
// last S/R change rather than tracking a settle state.
module tb_sr_latch_monitor;

  localparam int SETTLE = 2;
  localparam int CW     = 8;
  localparam int CMAX   = 255;

  localparam int MODE_UNK    = 0;
  localparam int MODE_CHECK  = 1;
  localparam int MODE_FORBID = 2;

`ifdef SRMON_FORBID_CHECK_EN
  localparam bit FORBID_EN = 1'b1;
`else
  localparam bit FORBID_EN = 1'b0;
`endif

  logic          clk = 1'b0;
  logic          rst;
  logic          clear;
  logic          exp_q;
  logic          exp_valid;
  logic          err;
  logic [1:0]    err_code;
  logic [CW-1:0] err_count;
  logic          invalid_seen;

  int tests_run    = 0;
  int tests_failed = 0;

  sr_latch_monitor_if lat_if ();

  sr_latch_monitor #(.SETTLE_CYCLES(SETTLE), .CNT_W(CW)) dut (
    .clk          (clk),
    .rst          (rst),
    .lat          (lat_if),
    .clear        (clear),
    .exp_q        (exp_q),
    .exp_valid    (exp_valid),
    .err          (err),
    .err_code     (err_code),
    .err_count    (err_count),
    .invalid_seen (invalid_seen)
  );

  // Free-running 10-unit clock
  always #5 clk = ~clk;

  // Behavioural reference state
  logic [1:0] m_prev_sr;
  bit         m_exp_q;
  bit         m_exp_valid;
  bit         m_err;
  logic [1:0] m_code;
  int         m_count;
  bit         m_inv;
  int         m_edge;
  int         m_last_change;
  int         m_mode;

  task automatic model_reset();
    m_prev_sr     = 2'b00;
    m_exp_q       = 1'b0;
    m_exp_valid   = 1'b0;
    m_err         = 1'b0;
    m_code        = 2'b00;
    m_count       = 0;
    m_inv         = 1'b0;
    m_edge        = 0;
    m_last_change = -1000;
    m_mode        = MODE_UNK;
  endtask

  // One clock edge of the reference: checks apply only more than SETTLE edges after the last change
  task automatic model_edge(input logic [1:0] sr, input logic q, input logic qb, input logic clr);
    bit         hit;
    logic [1:0] code;
    m_edge++;
    hit  = 1'b0;
    code = 2'b00;
    if (sr != m_prev_sr) begin
      if (sr == 2'b10) begin
        m_exp_q = 1'b1; m_exp_valid = 1'b1; m_mode = MODE_CHECK;
      end else if (sr == 2'b01) begin
        m_exp_q = 1'b0; m_exp_valid = 1'b1; m_mode = MODE_CHECK;
      end else if (sr == 2'b11) begin
        m_exp_valid = 1'b0; m_mode = MODE_FORBID;
      end else if (m_prev_sr == 2'b11) begin
        m_exp_valid = 1'b0; m_mode = MODE_UNK;
      end else begin
        m_mode = m_exp_valid ? MODE_CHECK : MODE_UNK;
      end
      m_last_change = m_edge;
    end else if (m_edge - m_last_change > SETTLE) begin
      if (m_mode == MODE_CHECK) begin
        if (q == qb) begin hit = 1'b1; code = 2'b10; end
        else if (q != m_exp_q) begin hit = 1'b1; code = 2'b01; end
      end else if (m_mode == MODE_FORBID && FORBID_EN && (q || qb)) begin
        hit = 1'b1; code = 2'b11;
      end
    end
    m_err = hit;
    if (hit) begin
      m_code = code;
      if (m_count < CMAX) m_count++;
    end
    if (sr == 2'b11) m_inv = 1'b1;
    if (clr) begin
      m_count = 0;
      m_inv   = (sr == 2'b11);
    end
    m_prev_sr = sr;
  endtask

  // Drive one cycle of inputs on the falling edge, then advance past the rising edge
  task automatic drive_cycle(input logic s, input logic r, input logic q, input logic qb, input logic clr);
    @(negedge clk);
    lat_if.s    = s;
    lat_if.r    = r;
    lat_if.q    = q;
    lat_if.qbar = qb;
    clear       = clr;
    @(posedge clk);
    model_edge({s, r}, q, qb, clr);
    #1;
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1;
    lat_if.s = 1'b0; lat_if.r = 1'b0; lat_if.q = 1'b0; lat_if.qbar = 1'b0;
    clear = 1'b0;
    #2;
    rst = 1'b0;
    model_reset();
  endtask

  task automatic test_reset();
    rst = 1'b1;
    lat_if.s = 1'b0; lat_if.r = 1'b0; lat_if.q = 1'b0; lat_if.qbar = 1'b1;
    clear = 1'b0;
    #1;
    tests_run++; if (err !== 1'b0) begin tests_failed++; $display("[TB] FAIL reset_err actual=%b required=0", err); end
    tests_run++; if (err_code !== 2'b00) begin tests_failed++; $display("[TB] FAIL reset_err_code actual=%b required=00", err_code); end
    tests_run++; if (err_count !== 8'd0) begin tests_failed++; $display("[TB] FAIL reset_err_count actual=%0d required=0", err_count); end
    tests_run++; if (invalid_seen !== 1'b0) begin tests_failed++; $display("[TB] FAIL reset_invalid actual=%b required=0", invalid_seen); end
    tests_run++; if (exp_valid !== 1'b0) begin tests_failed++; $display("[TB] FAIL reset_exp_valid actual=%b required=0", exp_valid); end
    tests_run++; if (exp_q !== 1'b0) begin tests_failed++; $display("[TB] FAIL reset_exp_q actual=%b required=0", exp_q); end
    @(negedge clk);
    rst = 1'b0;
    model_reset();
    drive_cycle(1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
    tests_run++; if (err !== 1'b0) begin tests_failed++; $display("[TB] FAIL reset_first_edge_err actual=%b required=0", err); end
    tests_run++; if (exp_valid !== 1'b0) begin tests_failed++; $display("[TB] FAIL reset_first_edge_valid actual=%b required=0", exp_valid); end
  endtask

  task automatic test_set_hold();
    bit saw_err;
    do_reset();
    saw_err = 1'b0;
    drive_cycle(1'b1, 1'b0, 1'b1, 1'b0, 1'b0);
    saw_err |= err;
    for (int i = 0; i < 10; i++) begin
      drive_cycle(1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
      saw_err |= err;
    end
    tests_run++; if (exp_q !== 1'b1) begin tests_failed++; $display("[TB] FAIL set_hold_exp_q actual=%b required=1", exp_q); end
    tests_run++; if (exp_valid !== 1'b1) begin tests_failed++; $display("[TB] FAIL set_hold_exp_valid actual=%b required=1", exp_valid); end
    tests_run++; if (saw_err !== 1'b0) begin tests_failed++; $display("[TB] FAIL set_hold_err_seen actual=%b required=0", saw_err); end
    tests_run++; if (err_count !== 8'd0) begin tests_failed++; $display("[TB] FAIL set_hold_count actual=%0d required=0", err_count); end
  endtask

  task automatic test_mismatch();
    do_reset();
    for (int i = 0; i < 3; i++) drive_cycle(1'b0, 1'b1, 1'b0, 1'b1, 1'b0);
    tests_run++; if (err !== 1'b0) begin tests_failed++; $display("[TB] FAIL mismatch_pre_err actual=%b required=0", err); end
    for (int k = 1; k <= 3; k++) begin
      drive_cycle(1'b0, 1'b1, 1'b1, 1'b0, 1'b0);
      tests_run++; if (err !== 1'b1) begin tests_failed++; $display("[TB] FAIL mismatch_err_%0d actual=%b required=1", k, err); end
      tests_run++; if (err_code !== 2'b01) begin tests_failed++; $display("[TB] FAIL mismatch_code_%0d actual=%b required=01", k, err_code); end
      tests_run++; if (err_count !== 8'(k)) begin tests_failed++; $display("[TB] FAIL mismatch_count_%0d actual=%0d required=%0d", k, err_count, k); end
    end
    drive_cycle(1'b0, 1'b1, 1'b0, 1'b1, 1'b0);
    tests_run++; if (err !== 1'b0) begin tests_failed++; $display("[TB] FAIL mismatch_release_err actual=%b required=0", err); end
    tests_run++; if (err_code !== 2'b01) begin tests_failed++; $display("[TB] FAIL mismatch_code_hold actual=%b required=01", err_code); end
    tests_run++; if (err_count !== 8'd3) begin tests_failed++; $display("[TB] FAIL mismatch_count_hold actual=%0d required=3", err_count); end
  endtask

  task automatic test_settle_window();
    do_reset();
    drive_cycle(1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
    for (int i = 1; i <= 2; i++) begin
      drive_cycle(1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
      tests_run++; if (err !== 1'b0) begin tests_failed++; $display("[TB] FAIL settle_e%0d_err actual=%b required=0", i, err); end
    end
    drive_cycle(1'b1, 1'b0, 1'b1, 1'b0, 1'b0);
    tests_run++; if (err !== 1'b0) begin tests_failed++; $display("[TB] FAIL settle_e3_err actual=%b required=0", err); end
    tests_run++; if (exp_q !== 1'b1) begin tests_failed++; $display("[TB] FAIL settle_exp_q actual=%b required=1", exp_q); end
    do_reset();
    drive_cycle(1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
    drive_cycle(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    for (int i = 2; i <= 3; i++) begin
      drive_cycle(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
      tests_run++; if (err !== 1'b0) begin tests_failed++; $display("[TB] FAIL restart_e%0d_err actual=%b required=0", i, err); end
    end
    drive_cycle(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    tests_run++; if (err !== 1'b1) begin tests_failed++; $display("[TB] FAIL restart_e4_err actual=%b required=1", err); end
    tests_run++; if (err_code !== 2'b10) begin tests_failed++; $display("[TB] FAIL restart_e4_code actual=%b required=10", err_code); end
    tests_run++; if (err_count !== 8'd1) begin tests_failed++; $display("[TB] FAIL restart_e4_count actual=%0d required=1", err_count); end
  endtask

  task automatic test_forbidden();
    bit saw_err;
    do_reset();
    for (int i = 0; i < 4; i++) drive_cycle(1'b1, 1'b0, 1'b1, 1'b0, 1'b0);
    drive_cycle(1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
    tests_run++; if (invalid_seen !== 1'b1) begin tests_failed++; $display("[TB] FAIL forbid_invalid actual=%b required=1", invalid_seen); end
    tests_run++; if (exp_valid !== 1'b0) begin tests_failed++; $display("[TB] FAIL forbid_exp_valid actual=%b required=0", exp_valid); end
    tests_run++; if (err !== 1'b0) begin tests_failed++; $display("[TB] FAIL forbid_e0_err actual=%b required=0", err); end
    drive_cycle(1'b1, 1'b1, 1'b1, 1'b0, 1'b0);
    drive_cycle(1'b1, 1'b1, 1'b1, 1'b0, 1'b0);
    tests_run++; if (err !== 1'b0) begin tests_failed++; $display("[TB] FAIL forbid_settle_err actual=%b required=0", err); end
    drive_cycle(1'b1, 1'b1, 1'b1, 1'b0, 1'b0);
    tests_run++; if (err !== FORBID_EN) begin tests_failed++; $display("[TB] FAIL forbid_check_err actual=%b required=%b", err, FORBID_EN); end
    tests_run++; if (err_code !== (FORBID_EN ? 2'b11 : 2'b00)) begin tests_failed++; $display("[TB] FAIL forbid_check_code actual=%b required=%b", err_code, FORBID_EN ? 2'b11 : 2'b00); end
    saw_err = 1'b0;
    for (int i = 0; i < 6; i++) begin
      drive_cycle(1'b0, 1'b0, 1'b1, 1'b1, 1'b0);
      saw_err |= err;
    end
    tests_run++; if (saw_err !== 1'b0) begin tests_failed++; $display("[TB] FAIL release_unk_err actual=%b required=0", saw_err); end
    tests_run++; if (exp_valid !== 1'b0) begin tests_failed++; $display("[TB] FAIL release_exp_valid actual=%b required=0", exp_valid); end
    tests_run++; if (invalid_seen !== 1'b1) begin tests_failed++; $display("[TB] FAIL release_invalid actual=%b required=1", invalid_seen); end
  endtask

  task automatic test_saturation_clear();
    do_reset();
    drive_cycle(1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
    for (int i = 0; i < 3; i++) drive_cycle(1'b0, 1'b1, 1'b0, 1'b1, 1'b0);
    for (int i = 0; i < 300; i++) drive_cycle(1'b0, 1'b1, 1'b1, 1'b0, 1'b0);
    tests_run++; if (err_count !== 8'd255) begin tests_failed++; $display("[TB] FAIL sat_count actual=%0d required=255", err_count); end
    tests_run++; if (invalid_seen !== 1'b1) begin tests_failed++; $display("[TB] FAIL sat_invalid actual=%b required=1", invalid_seen); end
    drive_cycle(1'b0, 1'b1, 1'b1, 1'b0, 1'b1);
    tests_run++; if (err_count !== 8'd0) begin tests_failed++; $display("[TB] FAIL clear_count actual=%0d required=0", err_count); end
    tests_run++; if (invalid_seen !== 1'b0) begin tests_failed++; $display("[TB] FAIL clear_invalid actual=%b required=0", invalid_seen); end
    tests_run++; if (err !== 1'b1) begin tests_failed++; $display("[TB] FAIL clear_err actual=%b required=1", err); end
    tests_run++; if (err_code !== 2'b01) begin tests_failed++; $display("[TB] FAIL clear_code actual=%b required=01", err_code); end
    drive_cycle(1'b0, 1'b1, 1'b1, 1'b0, 1'b0);
    tests_run++; if (err_count !== 8'd1) begin tests_failed++; $display("[TB] FAIL after_clear_count actual=%0d required=1", err_count); end
    drive_cycle(1'b1, 1'b1, 1'b0, 1'b0, 1'b1);
    tests_run++; if (err_count !== 8'd0) begin tests_failed++; $display("[TB] FAIL clear11_count actual=%0d required=0", err_count); end
    tests_run++; if (invalid_seen !== 1'b1) begin tests_failed++; $display("[TB] FAIL clear11_invalid actual=%b required=1", invalid_seen); end
  endtask

  task automatic test_async_reset();
    do_reset();
    for (int i = 0; i < 3; i++) drive_cycle(1'b0, 1'b1, 1'b0, 1'b1, 1'b0);
    drive_cycle(1'b0, 1'b1, 1'b1, 1'b0, 1'b0);
    drive_cycle(1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
    drive_cycle(1'b1, 1'b0, 1'b1, 1'b0, 1'b0);
    tests_run++; if (exp_valid !== 1'b1) begin tests_failed++; $display("[TB] FAIL async_pre_valid actual=%b required=1", exp_valid); end
    tests_run++; if (err_count !== 8'd1) begin tests_failed++; $display("[TB] FAIL async_pre_count actual=%0d required=1", err_count); end
    #3;
    rst = 1'b1;
    #1;
    tests_run++; if (exp_valid !== 1'b0) begin tests_failed++; $display("[TB] FAIL async_exp_valid actual=%b required=0", exp_valid); end
    tests_run++; if (exp_q !== 1'b0) begin tests_failed++; $display("[TB] FAIL async_exp_q actual=%b required=0", exp_q); end
    tests_run++; if (err_code !== 2'b00) begin tests_failed++; $display("[TB] FAIL async_err_code actual=%b required=00", err_code); end
    tests_run++; if (err_count !== 8'd0) begin tests_failed++; $display("[TB] FAIL async_err_count actual=%0d required=0", err_count); end
    tests_run++; if (invalid_seen !== 1'b0) begin tests_failed++; $display("[TB] FAIL async_invalid actual=%b required=0", invalid_seen); end
    tests_run++; if (err !== 1'b0) begin tests_failed++; $display("[TB] FAIL async_err actual=%b required=0", err); end
    #1;
    rst = 1'b0;
    model_reset();
    drive_cycle(1'b1, 1'b0, 1'b1, 1'b0, 1'b0);
    tests_run++; if (exp_valid !== 1'b1) begin tests_failed++; $display("[TB] FAIL post_reset_valid actual=%b required=1", exp_valid); end
    tests_run++; if (exp_q !== 1'b1) begin tests_failed++; $display("[TB] FAIL post_reset_exp_q actual=%b required=1", exp_q); end
    tests_run++; if (err !== 1'b0) begin tests_failed++; $display("[TB] FAIL post_reset_err actual=%b required=0", err); end
  endtask

  task automatic test_random();
    logic [1:0] sr;
    logic [1:0] last_sr;
    logic [1:0] qq;
    bit         lq;
    bit         clr;
    do_reset();
    sr = 2'b00;
    last_sr = 2'b00;
    lq = 1'b0;
    for (int n = 0; n < 1500; n++) begin
      if ($urandom_range(0, 3) == 0) sr = 2'($urandom_range(0, 3));
      if (sr == 2'b10) lq = 1'b1;
      else if (sr == 2'b01) lq = 1'b0;
      else if (sr == 2'b00 && last_sr == 2'b11) lq = 1'($urandom_range(0, 1));
      qq = (sr == 2'b11) ? 2'b00 : {lq, ~lq};
      if ($urandom_range(0, 9) == 0) qq = 2'($urandom_range(0, 3));
      clr = ($urandom_range(0, 39) == 0);
      drive_cycle(sr[1], sr[0], qq[1], qq[0], clr);
      last_sr = sr;
      tests_run++; if (err !== m_err) begin tests_failed++; $display("[TB] FAIL rand_err cyc=%0d actual=%b required=%b", n, err, m_err); end
      tests_run++; if (err_code !== m_code) begin tests_failed++; $display("[TB] FAIL rand_code cyc=%0d actual=%b required=%b", n, err_code, m_code); end
      tests_run++; if (err_count !== m_count[CW-1:0]) begin tests_failed++; $display("[TB] FAIL rand_count cyc=%0d actual=%0d required=%0d", n, err_count, m_count); end
      tests_run++; if (invalid_seen !== m_inv) begin tests_failed++; $display("[TB] FAIL rand_invalid cyc=%0d actual=%b required=%b", n, invalid_seen, m_inv); end
      tests_run++; if (exp_valid !== m_exp_valid) begin tests_failed++; $display("[TB] FAIL rand_exp_valid cyc=%0d actual=%b required=%b", n, exp_valid, m_exp_valid); end
      if (m_exp_valid) begin
        tests_run++; if (exp_q !== m_exp_q) begin tests_failed++; $display("[TB] FAIL rand_exp_q cyc=%0d actual=%b required=%b", n, exp_q, m_exp_q); end
      end
    end
  endtask

  // Hard stop in case the sequence ever stalls
  initial begin
    #1000000;
    $display("[TB] FAIL watchdog actual=timeout required=finish");
    $fatal(1, "[TB] watchdog expired");
  end

  // Scenario sequence and summary
  initial begin
    test_reset();
    test_set_hold();
    test_mismatch();
    test_settle_window();
    test_forbidden();
    test_saturation_clear();
    test_async_reset();
    test_random();
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
